// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage plus the IF/ID pipeline register.
// Holds the PC, reads 16-bit words from a word-addressed instruction memory
// and assembles two-word instructions (opcode + immediate) into one entry.
// Stall, flush and redirect requests arrive from later pipeline stages.
module fetch_unit #(
  parameter int                    ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [15:0]           imem_data,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic [15:0]           instr_out,
  output logic [15:0]           imm_out,
  output logic [ADDR_WIDTH-1:0] pc_out,
  output logic [ADDR_WIDTH-1:0] next_pc_out,
  output logic                  valid_out
);

  // NOP encoding (opcode 11111) used for every bubble written into IF/ID.
  localparam logic [15:0] NOP_WORD = 16'hF800;

  // FIRST: the word at PC is an opcode. SECOND: the word at PC is the
  // immediate belonging to the opcode captured in hold_instr_q.
  typedef enum logic {
    FIRST  = 1'b0,
    SECOND = 1'b1
  } state_t;

  // Opcodes that carry a trailing immediate word.
  function automatic logic is_two_word(input logic [4:0] opcode);
    case (opcode)
      5'b00111,             // LDM
      5'b01110,             // LDD
      5'b01111,             // STD
      5'b10100,             // SHL
      5'b10101: return 1'b1; // SHR
      default:  return 1'b0;
    endcase
  endfunction

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [15:0]           hold_instr_q, hold_instr_d;
  logic [ADDR_WIDTH-1:0] hold_pc_q, hold_pc_d;
  logic [15:0]           instr_q, instr_d;
  logic [15:0]           imm_q, imm_d;
  logic [ADDR_WIDTH-1:0] pc_out_q, pc_out_d;
  logic [ADDR_WIDTH-1:0] next_pc_out_q, next_pc_out_d;
  logic                  valid_q, valid_d;

  // Wraps modulo 2^ADDR_WIDTH by construction of the width.
  logic [ADDR_WIDTH-1:0] pc_plus1;
  logic                  opcode_two_word;

  assign pc_plus1        = pc_q + ADDR_WIDTH'(1);
  assign opcode_two_word = is_two_word(imem_data[15:11]);

  // Memory is addressed straight from the PC register (no extra stage).
  assign imem_addr   = pc_q;
  assign instr_out   = instr_q;
  assign imm_out     = imm_q;
  assign pc_out      = pc_out_q;
  assign next_pc_out = next_pc_out_q;
  assign valid_out   = valid_q;

  // Next-state logic: redirect > flush > stall > normal fetch.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    hold_instr_d  = hold_instr_q;
    hold_pc_d     = hold_pc_q;
    instr_d       = instr_q;
    imm_d         = imm_q;
    pc_out_d      = pc_out_q;
    next_pc_out_d = next_pc_out_q;
    valid_d       = valid_q;

    if (redirect) begin
      // Control-flow change wins over everything; any half-assembled pair
      // is abandoned and fetch restarts at the target in FIRST.
      pc_d         = redirect_pc;
      state_d      = FIRST;
      hold_instr_d = '0;
      hold_pc_d    = '0;
      instr_d      = NOP_WORD;
      imm_d        = '0;
      valid_d      = 1'b0;
    end else if (stall) begin
      // Stalled: PC, FSM and hold registers freeze. A simultaneous flush
      // still squashes the IF/ID contents.
      if (flush) begin
        instr_d = NOP_WORD;
        imm_d   = '0;
        valid_d = 1'b0;
      end
    end else begin
      // Fetch advances normally; flush only replaces what would have been
      // written into IF/ID with a bubble.
      pc_d = pc_plus1;
      if (state_q == FIRST) begin
        if (opcode_two_word) begin
          hold_instr_d = imem_data;
          hold_pc_d    = pc_q;
          state_d      = SECOND;
          instr_d      = NOP_WORD;
          imm_d        = '0;
          valid_d      = 1'b0;
        end else if (flush) begin
          instr_d = NOP_WORD;
          imm_d   = '0;
          valid_d = 1'b0;
        end else begin
          instr_d       = imem_data;
          imm_d         = '0;
          pc_out_d      = pc_q;
          next_pc_out_d = pc_plus1;
          valid_d       = 1'b1;
        end
      end else begin
        // Word at PC is the immediate; it is never decoded as an opcode.
        state_d = FIRST;
        if (flush) begin
          instr_d = NOP_WORD;
          imm_d   = '0;
          valid_d = 1'b0;
        end else begin
          instr_d       = hold_instr_q;
          imm_d         = imem_data;
          pc_out_d      = hold_pc_q;
          next_pc_out_d = pc_plus1;
          valid_d       = 1'b1;
        end
      end
    end
  end

  // State, PC, hold and IF/ID registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= FIRST;
      pc_q          <= RESET_PC;
      hold_instr_q  <= '0;
      hold_pc_q     <= '0;
      instr_q       <= NOP_WORD;
      imm_q         <= '0;
      pc_out_q      <= '0;
      next_pc_out_q <= '0;
      valid_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      hold_instr_q  <= hold_instr_d;
      hold_pc_q     <= hold_pc_d;
      instr_q       <= instr_d;
      imm_q         <= imm_d;
      pc_out_q      <= pc_out_d;
      next_pc_out_q <= next_pc_out_d;
      valid_q       <= valid_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed stimulus for fetch_unit with an instruction-stream
// reference model and per-cycle output comparison, plus literal checkpoints.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic [15:0] instr_out;
  logic [15:0] imm_out;
  logic [15:0] pc_out;
  logic [15:0] next_pc_out;
  logic        valid_out;

  int errors = 0;
  int checks = 0;

  logic [15:0] mem [0:65535];

  fetch_unit #(.ADDR_WIDTH(16), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .stall(stall), .flush(flush),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .instr_out(instr_out), .imm_out(imm_out),
    .pc_out(pc_out), .next_pc_out(next_pc_out),
    .valid_out(valid_out)
  );

  always #5 clk = ~clk;

  assign imem_data = mem[imem_addr];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Words fetched for the instruction being assembled are collected in a
  // queue; the entry is emitted once the queue holds as many words as the
  // first word's opcode demands.
  function automatic int instr_len(input logic [15:0] w);
    logic [4:0] op;
    op = w[15:11];
    if (op == 5'b00111 || op == 5'b01110 || op == 5'b01111 ||
        op == 5'b10100 || op == 5'b10101) return 2;
    return 1;
  endfunction

  logic [15:0] m_pc;
  logic [15:0] m_words[$];
  logic [15:0] m_start;
  logic [15:0] e_instr, e_imm, e_pc, e_npc;
  logic        e_valid;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc = 16'h0000;
      m_words.delete();
      m_start = '0;
      e_instr = 16'hF800; e_imm = '0; e_pc = '0; e_npc = '0; e_valid = 1'b0;
    end else if (redirect) begin
      m_pc = redirect_pc;
      m_words.delete();
      e_instr = 16'hF800; e_imm = '0; e_valid = 1'b0;
    end else if (stall) begin
      if (flush) begin
        e_instr = 16'hF800; e_imm = '0; e_valid = 1'b0;
      end
    end else begin
      if (m_words.size() == 0) m_start = m_pc;
      m_words.push_back(mem[m_pc]);
      m_pc = m_pc + 16'd1;
      if (m_words.size() == instr_len(m_words[0])) begin
        if (flush) begin
          e_instr = 16'hF800; e_imm = '0; e_valid = 1'b0;
        end else begin
          e_instr = m_words[0];
          e_imm   = (m_words.size() == 2) ? m_words[1] : 16'h0000;
          e_pc    = m_start;
          e_npc   = m_pc;
          e_valid = 1'b1;
        end
        m_words.delete();
      end else begin
        e_instr = 16'hF800; e_imm = '0; e_valid = 1'b0;
      end
    end
  end

  // Per-cycle comparison on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      check("cyc_imem_addr", imem_addr, m_pc);
      check("cyc_instr", instr_out, e_instr);
      check("cyc_imm", imm_out, e_imm);
      check("cyc_pc_out", pc_out, e_pc);
      check("cyc_next_pc", next_pc_out, e_npc);
      check("cyc_valid", 16'(valid_out), 16'(e_valid));
    end
  end

  // ---------------- stimulus ----------------
  // Apply inputs for the next rising edge, then return at the following
  // falling edge so the result of that edge can be inspected.
  task automatic step(input logic r, input logic f, input logic s, input logic [15:0] tgt);
    redirect = r; flush = f; stall = s; redirect_pc = tgt;
    @(negedge clk);
    redirect = 1'b0; flush = 1'b0; stall = 1'b0;
  endtask

  task automatic expect_entry(input string name, input logic [15:0] ins, input logic [15:0] imm,
                              input logic [15:0] pc, input logic [15:0] npc);
    check({name, "_instr"}, instr_out, ins);
    check({name, "_imm"}, imm_out, imm);
    check({name, "_pc"}, pc_out, pc);
    check({name, "_npc"}, next_pc_out, npc);
    check({name, "_valid"}, 16'(valid_out), 16'h0001);
  endtask

  task automatic expect_bubble(input string name);
    check({name, "_instr"}, instr_out, 16'hF800);
    check({name, "_imm"}, imm_out, 16'h0000);
    check({name, "_valid"}, 16'(valid_out), 16'h0000);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = {5'b00001, 11'(i)};
    mem[16'h0000] = 16'h0000;  // ADD
    mem[16'h0001] = 16'h2000;  // OUT
    mem[16'h0004] = 16'h3800;  // LDM
    mem[16'h0005] = 16'h1234;
    mem[16'h0010] = 16'h7000;  // LDD
    mem[16'h0011] = 16'hBEEF;
    mem[16'h0020] = 16'hA000;  // SHL
    mem[16'h0021] = 16'h5555;
    mem[16'h0040] = 16'h4040;  // one-word

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    expect_bubble("reset");
    check("reset_pc_out", pc_out, 16'h0000);
    check("reset_npc", next_pc_out, 16'h0000);
    check("reset_addr", imem_addr, 16'h0000);

    // Sequential one-word instructions.
    step(0, 0, 0, 0);
    expect_entry("add", 16'h0000, 16'h0000, 16'h0000, 16'h0001);
    step(0, 0, 0, 0);
    expect_entry("out", 16'h2000, 16'h0000, 16'h0001, 16'h0002);
    $display("one-word sequence done");

    // Two-word LDM at 4.
    step(1, 0, 0, 16'h0004);
    check("ldm_redir_addr", imem_addr, 16'h0004);
    step(0, 0, 0, 0);
    expect_bubble("ldm_edge1");
    step(0, 0, 0, 0);
    expect_entry("ldm", 16'h3800, 16'h1234, 16'h0004, 16'h0006);
    check("ldm_addr_after", imem_addr, 16'h0006);
    $display("two-word LDM done");

    // Stall three cycles while in SECOND.
    step(1, 0, 0, 16'h0010);
    step(0, 0, 0, 0);
    check("stall_pre_addr", imem_addr, 16'h0011);
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 1, 0);
      check("stall_addr", imem_addr, 16'h0011);
      expect_bubble("stall_hold");
    end
    step(0, 0, 0, 0);
    expect_entry("ldd", 16'h7000, 16'hBEEF, 16'h0010, 16'h0012);
    $display("stall in SECOND done");

    // Redirect while in SECOND drops the pending pair.
    step(1, 0, 0, 16'h0020);
    step(0, 0, 0, 0);
    check("redir_second_addr", imem_addr, 16'h0021);
    step(1, 0, 0, 16'h0040);
    check("redir_addr", imem_addr, 16'h0040);
    expect_bubble("redir_bubble");
    step(0, 0, 0, 0);
    expect_entry("target", 16'h4040, 16'h0000, 16'h0040, 16'h0041);
    $display("redirect in SECOND done");

    // Flush alone at 8, then flush+stall at 9.
    step(1, 0, 0, 16'h0008);
    step(0, 1, 0, 0);
    expect_bubble("flush");
    check("flush_addr", imem_addr, 16'h0009);
    check("flush_keep_pc_out", pc_out, 16'h0040);
    step(0, 1, 1, 0);
    expect_bubble("flush_stall");
    check("flush_stall_addr", imem_addr, 16'h0009);
    step(0, 0, 0, 0);
    expect_entry("after_flush", 16'h0809, 16'h0000, 16'h0009, 16'h000A);
    $display("flush cases done");

    // Flush in SECOND drops the LDM pair; fetch continues at 6.
    step(1, 0, 0, 16'h0004);
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    expect_bubble("flush_second");
    check("flush_second_addr", imem_addr, 16'h0006);
    step(0, 0, 0, 0);
    expect_entry("after_drop", 16'h0806, 16'h0000, 16'h0006, 16'h0007);
    $display("flush in SECOND done");

    // Wrap-around at 0xFFFF.
    step(1, 0, 0, 16'hFFFF);
    step(0, 0, 0, 0);
    expect_entry("wrap", 16'h0FFF, 16'h0000, 16'hFFFF, 16'h0000);
    check("wrap_addr", imem_addr, 16'h0000);
    $display("wrap-around done");

    // Asynchronous reset in the middle of a cycle.
    #2 rst_n = 1'b0;
    #1;
    expect_bubble("async_rst");
    check("async_rst_pc_out", pc_out, 16'h0000);
    check("async_rst_npc", next_pc_out, 16'h0000);
    check("async_rst_addr", imem_addr, 16'h0000);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, 0, 0);
    expect_entry("post_rst", 16'h0000, 16'h0000, 16'h0000, 16'h0001);
    $display("async reset done");

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
